// File: rtl/vga_stream_monitor.sv
// rtl/vga_stream_monitor.sv - video bus timing checker: lock FSM, x/y recovery, fault count; FRAME_CRC_EN adds crc_out
module vga_stream_monitor #(
    parameter int   H_TOTAL     = 1344,
    parameter int   V_TOTAL     = 806,
    parameter int   H_ACTIVE    = 1024,
    parameter int   V_ACTIVE    = 768,
    parameter int   LOCK_FRAMES = 2,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] x_out,
    output logic [10:0] y_out,
    output logic        de_out,
    output logic        frame_strobe,
    output logic        locked,
    output logic [7:0]  err_count
`ifdef FRAME_CRC_EN
    ,
    output logic [15:0] crc_out
`endif
);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    localparam logic [10:0] H_TOT  = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT  = 11'(V_TOTAL);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

    function automatic logic [10:0] inc_sat(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    logic hs_r, vs_r, hb_r, vb_r;
    logic hs_p, vs_p, hb_p;
    logic hs_edge, vs_edge, hb_rise, act_line_end;
    logic [10:0] hcnt, acnt, lcnt, vacnt, px, py;
    logic [10:0] lcnt_eff, vacnt_eff, py_n;
    logic skip_h;
    logic h_fail, a_fail, f_fail, fail;
    state_t state, state_n;
    logic [3:0] good, good_n;
    logic frame_bad, frame_bad_n, err_inc;

    // Registered input copies plus one more stage for edge detection; reset to blank/inactive.
    always_ff @(posedge pclk) begin
        if (rst) begin
            hs_r <= ~SYNC_POL;
            vs_r <= ~SYNC_POL;
            hb_r <= 1'b1;
            vb_r <= 1'b1;
            hs_p <= ~SYNC_POL;
            vs_p <= ~SYNC_POL;
            hb_p <= 1'b1;
        end else begin
            hs_r <= hsync_in;
            vs_r <= vsync_in;
            hb_r <= hblnk_in;
            vb_r <= vblnk_in;
            hs_p <= hs_r;
            vs_p <= vs_r;
            hb_p <= hb_r;
        end
    end

    always_comb begin
        hs_edge      = (hs_r == SYNC_POL) && (hs_p != SYNC_POL);
        vs_edge      = (vs_r == SYNC_POL) && (vs_p != SYNC_POL);
        hb_rise      = hb_r && !hb_p;
        act_line_end = hb_rise && !vb_r;
        // A line edge coinciding with the frame edge belongs to the ending frame.
        lcnt_eff     = hs_edge ? inc_sat(lcnt) : lcnt;
        vacnt_eff    = act_line_end ? inc_sat(vacnt) : vacnt;
        py_n         = vb_r ? 11'd0 : (act_line_end ? inc_sat(py) : py);
        h_fail       = hs_edge && !skip_h && (hcnt != H_TOT);
        a_fail       = act_line_end && (acnt != H_ACT);
        f_fail       = vs_edge && ((lcnt_eff != V_TOT) || (vacnt_eff != V_ACT));
        fail         = h_fail || a_fail || f_fail;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcnt   <= 11'd0;
            acnt   <= 11'd0;
            lcnt   <= 11'd0;
            vacnt  <= 11'd0;
            px     <= 11'd0;
            py     <= 11'd0;
            skip_h <= 1'b1;
        end else begin
            hcnt   <= hs_edge ? 11'd1 : inc_sat(hcnt);
            acnt   <= hb_rise ? 11'd0 : (!hb_r ? inc_sat(acnt) : acnt);
            lcnt   <= vs_edge ? 11'd0 : lcnt_eff;
            vacnt  <= vs_edge ? 11'd0 : vacnt_eff;
            px     <= hb_r ? 11'd0 : inc_sat(px);
            py     <= py_n;
            // hcnt is not trustworthy until one full line has been seen outside SEARCH.
            skip_h <= (state == SEARCH) ? 1'b1 : (hs_edge ? 1'b0 : skip_h);
        end
    end

    always_comb begin
        state_n     = state;
        good_n      = good;
        frame_bad_n = frame_bad;
        err_inc     = 1'b0;
        case (state)
            SEARCH: begin
                if (vs_edge) begin
                    state_n     = MEASURE;
                    good_n      = 4'd0;
                    frame_bad_n = 1'b0;
                end
            end
            MEASURE: begin
                if (vs_edge) begin
                    frame_bad_n = 1'b0;
                    if (fail || frame_bad) begin
                        good_n = 4'd0;
                    end else begin
                        good_n = good + 4'd1;
                        if (good + 4'd1 == LOCK_N) state_n = LOCKED;
                    end
                end else if (fail) begin
                    good_n      = 4'd0;
                    frame_bad_n = 1'b1;
                end
            end
            LOCKED: begin
                if (fail) begin
                    err_inc = 1'b1;
                    state_n = SEARCH;
                    good_n  = 4'd0;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state     <= SEARCH;
            good      <= 4'd0;
            frame_bad <= 1'b0;
        end else begin
            state     <= state_n;
            good      <= good_n;
            frame_bad <= frame_bad_n;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            x_out        <= 11'd0;
            y_out        <= 11'd0;
            de_out       <= 1'b0;
            frame_strobe <= 1'b0;
            locked       <= 1'b0;
            err_count    <= 8'd0;
        end else begin
            x_out        <= (hb_r || vb_r) ? 11'd0 : px;
            y_out        <= py_n;
            de_out       <= !hb_r && !vb_r;
            frame_strobe <= vs_edge;
            locked       <= (state_n == LOCKED);
            if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

`ifdef FRAME_CRC_EN
    logic [11:0] rgb_r;
    logic [15:0] crc;

    function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 11; i >= 0; i--) begin
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    always_ff @(posedge pclk) begin
        if (rst) begin
            rgb_r   <= 12'd0;
            crc     <= 16'hFFFF;
            crc_out <= 16'd0;
        end else begin
            rgb_r <= rgb_in;
            if (vs_edge) begin
                crc_out <= crc;
                crc     <= 16'hFFFF;
            end else if (!hb_r && !vb_r) begin
                crc <= crc12(crc, rgb_r);
            end
        end
    end
`else
    logic unused_rgb;
    assign unused_rgb = ^rgb_in;
`endif

endmodule

// File: tb/tb_vga_stream_monitor.sv
// tb/tb_vga_stream_monitor.sv - table-driven and randomized frame bench for vga_stream_monitor
module tb_vga_stream_monitor;
    localparam int HT = 16;
    localparam int HA = 10;
    localparam int VT = 8;
    localparam int VA = 5;

    logic        pclk = 1'b0;
    logic        rst = 1'b1;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, hblnk_in = 1'b1, vblnk_in = 1'b1;
    logic [11:0] rgb_in = 12'd0;
    logic [10:0] x_out, y_out;
    logic        de_out, frame_strobe, locked;
    logic [7:0]  err_count;
`ifdef FRAME_CRC_EN
    logic [15:0] crc_out;
`endif

    int checks = 0;
    int failures = 0;

    vga_stream_monitor #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
        .LOCK_FRAMES(2), .SYNC_POL(1'b0)
    ) dut (
        .pclk(pclk), .rst(rst),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .x_out(x_out), .y_out(y_out), .de_out(de_out),
        .frame_strobe(frame_strobe), .locked(locked), .err_count(err_count)
`ifdef FRAME_CRC_EN
        , .crc_out(crc_out)
`endif
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int   s_line;
        int   s_n;
        int   d_line;
        int   r_line;
        logic e_locked;
        int   e_err;
    } row_t;

    row_t rows[17];

    logic        p_valid = 1'b0, p_chk = 1'b0, p_de = 1'b0, p_fs = 1'b0, coord_ok = 1'b0;
    logic [10:0] p_x = 11'd0, p_y = 11'd0;
    int          locked_at_fs;
    int          m_mode = 0, m_good = 0, m_err = 0;
    logic [15:0] m_crc = 16'hFFFF, p_crc = 16'hFFFF;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [11:0] d);
        logic [15:0] r;
        r = c ^ {d, 4'b0000};
        repeat (12) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
        return r;
    endfunction

    task automatic tick(input logic hs, input logic vs, input logic hb, input logic vb, input logic r,
                        input logic [11:0] rgb, input logic [10:0] ex, input logic [10:0] ey,
                        input logic fs_e);
        hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb; rst = r; rgb_in = rgb;
        @(posedge pclk);
        #1;
        if (r) begin
            chk("rst_x", x_out, 0);
            chk("rst_y", y_out, 0);
            chk("rst_de", de_out, 0);
            chk("rst_strobe", frame_strobe, 0);
            chk("rst_locked", locked, 0);
            chk("rst_err", err_count, 0);
            p_valid = 1'b0;
            coord_ok = 1'b0;
            m_crc = 16'hFFFF;
        end else begin
            if (p_valid) begin
                chk("frame_strobe", frame_strobe, p_fs);
                if (p_chk) begin
                    chk("x_out", x_out, p_x);
                    chk("y_out", y_out, p_y);
                    chk("de_out", de_out, p_de);
                end
                if (p_fs) begin
                    locked_at_fs = locked;
`ifdef FRAME_CRC_EN
                    chk("crc_out", crc_out, p_crc);
`endif
                end
            end
            if (hb && vb) coord_ok = 1'b1;
            p_valid = 1'b1;
            p_chk = coord_ok;
            p_x = ex;
            p_y = ey;
            p_de = !hb && !vb;
            p_fs = fs_e;
            if (fs_e) begin
                p_crc = m_crc;
                m_crc = 16'hFFFF;
            end else if (!hb && !vb) begin
                m_crc = crc_upd(m_crc, rgb);
            end
        end
    endtask

    // One frame: lines 0..VA-1 active, vsync asserted from line 6 (with hsync) to line 7.
    task automatic run_frame(input int s_line, input int s_n, input int d_line, input int r_line,
                             input logic rand_rgb, input int mid_err);
        int ay, len;
        logic hb, vb, hs, vs, fs, r;
        logic [10:0] ex, ey;
        logic [11:0] pix;
        ay = 0;
        locked_at_fs = 2;
        for (int l = 0; l < VT; l++) begin
            if (l != d_line) begin
                len = HT + ((l == s_line) ? s_n : 0);
                vb = (l >= VA);
                for (int c = 0; c < len; c++) begin
                    hb = (c >= HA);
                    hs = !(c == 12 || c == 13);
                    vs = !((l == 6 && c >= 12) || (l == 7 && c < 12));
                    fs = (l == 6 && c == 12);
                    r = (l == r_line && c == 5);
                    ex = (hb || vb) ? 11'd0 : 11'(c);
                    ey = vb ? 11'd0 : 11'(hb ? ay + 1 : ay);
                    pix = rand_rgb ? 12'($urandom) : 12'hF00;
                    tick(hs, vs, hb, vb, r, pix, ex, ey, fs);
                end
                if (!vb) ay++;
                if (s_line >= 0 && l == s_line + 1) begin
                    chk("mid_locked", locked, 0);
                    chk("mid_err", err_count, mid_err);
                end
            end
        end
    endtask

    // Frame-level lock model: fault 0 none, 1 mid-frame line fault, 2 fault found at the vsync edge.
    task automatic model_frame(input int fault, input logic rst_in);
        if (rst_in) begin
            m_mode = 0; m_good = 0; m_err = 0;
        end
        if (m_mode == 2) begin
            if (fault != 0) begin
                if (m_err < 255) m_err++;
                m_mode = (fault == 1) ? 1 : 0;
                m_good = 0;
            end
        end else if (m_mode == 0) begin
            m_mode = 1;
            m_good = 0;
        end else begin
            if (fault != 0) m_good = 0;
            else begin
                m_good++;
                if (m_good == 2) m_mode = 2;
            end
        end
    endtask

    function automatic int fault_of(input int s_line, input int d_line);
        return (s_line >= 0) ? 1 : ((d_line >= 0) ? 2 : 0);
    endfunction

    initial begin
        int s_line, s_n, d_line, kind, mid_err;
        rows[0]  = '{-1, 0, -1, -1, 1'b0, 0};
        rows[1]  = '{-1, 0, -1, -1, 1'b0, 0};
        rows[2]  = '{-1, 0, -1, -1, 1'b1, 0};
        rows[3]  = '{ 2, 1, -1, -1, 1'b0, 1};
        rows[4]  = '{-1, 0, -1, -1, 1'b0, 1};
        rows[5]  = '{-1, 0, -1, -1, 1'b1, 1};
        rows[6]  = '{-1, 0,  5, -1, 1'b0, 2};
        rows[7]  = '{-1, 0, -1, -1, 1'b0, 2};
        rows[8]  = '{-1, 0, -1, -1, 1'b0, 2};
        rows[9]  = '{-1, 0, -1, -1, 1'b1, 2};
        rows[10] = '{-1, 0,  3, -1, 1'b0, 3};
        rows[11] = '{-1, 0, -1, -1, 1'b0, 3};
        rows[12] = '{-1, 0, -1, -1, 1'b0, 3};
        rows[13] = '{-1, 0, -1, -1, 1'b1, 3};
        rows[14] = '{-1, 0, -1,  2, 1'b0, 0};
        rows[15] = '{-1, 0, -1, -1, 1'b0, 0};
        rows[16] = '{-1, 0, -1, -1, 1'b1, 0};

        repeat (3) tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 12'd0, 11'd0, 11'd0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            mid_err = (rows[i].s_line >= 0 && m_mode == 2) ? m_err + 1 : m_err;
            run_frame(rows[i].s_line, rows[i].s_n, rows[i].d_line, rows[i].r_line, 1'b0, mid_err);
            model_frame(fault_of(rows[i].s_line, rows[i].d_line), rows[i].r_line >= 0);
            chk($sformatf("row%0d_locked", i), locked_at_fs, rows[i].e_locked);
            chk($sformatf("row%0d_err", i), err_count, rows[i].e_err);
        end

        for (int f = 0; f < 24; f++) begin
            kind = $urandom_range(0, 5);
            s_line = -1; s_n = 0; d_line = -1;
            if (kind == 3) begin
                s_line = $urandom_range(0, VA - 1);
                s_n = $urandom_range(1, 2);
            end else if (kind == 4) begin
                d_line = VA;
            end else if (kind == 5) begin
                d_line = $urandom_range(0, VA - 1);
            end
            mid_err = (s_line >= 0 && m_mode == 2) ? m_err + 1 : m_err;
            run_frame(s_line, s_n, d_line, -1, 1'b1, mid_err);
            model_frame(fault_of(s_line, d_line), 1'b0);
            chk($sformatf("rand%0d_locked", f), locked_at_fs, (m_mode == 2) ? 1 : 0);
            chk($sformatf("rand%0d_err", f), err_count, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
